// File: rtl/snn_neuron_delay_param.sv
// LIF neuron with per-synapse programmable axonal delay lines, saturating
// integration, refractory FSM and a saturating output spike counter.

// One synapse: tick-stepped shift register plus delay tap / bypass select.
module snn_delay_lane #(
    parameter int DMAX = 7,
    parameter int DW   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          shift_en,
    input  logic          spike_in,
    input  logic [DW-1:0] delay_value,
    input  logic          delay_en,
    output logic          delayed_spike
);
    logic [DMAX-1:0] sr;
    logic [DW-1:0]   d;
    logic            tap;

    // Shift the raw spike in only on enabled tick cycles.
    always_ff @(posedge clk) begin
        if (reset)
            sr <= '0;
        else if (shift_en)
            sr <= DMAX'({sr, spike_in});
    end

    // Clamp the delay to the line depth, then pick the tap (d ticks old).
    always_comb begin
        d   = (delay_value > DW'(DMAX)) ? DW'(DMAX) : delay_value;
        tap = 1'b0;
        for (int k = 0; k < DMAX; k++)
            if (d == DW'(k + 1)) tap = sr[k];
        delayed_spike = (!delay_en || d == '0) ? spike_in : tap;
    end
endmodule

module snn_neuron_delay_param #(
    parameter int M     = 2,
    parameter int NBITS = 4,
    parameter int DMAX  = 7,
    parameter int DW    = $clog2(DMAX + 1),
    parameter int CW    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              delay_tick,
    input  logic [M-1:0]      input_spikes,
    input  logic [M*NBITS-1:0] weights,
    input  logic [NBITS-1:0]  threshold,
    input  logic [NBITS-1:0]  decay,
    input  logic [NBITS-1:0]  refractory_period,
    input  logic [M*DW-1:0]   delay_values,
    input  logic [M-1:0]      delay_en,
    output logic [NBITS-1:0]  membrane_potential_out,
    output logic              spike_out,
    output logic              refractory_out,
    output logic [CW-1:0]     spike_count
);
    localparam int SW = NBITS + $clog2(M);
    localparam logic [NBITS-1:0] VMAX = '1;
    localparam logic [CW-1:0]    CMAX = '1;

    typedef enum logic {INTEGRATE, REFRACTORY} state_t;

    state_t                   state;
    logic [NBITS-1:0]         v;
    logic [NBITS-1:0]         refr_cnt;
    logic [M-1:0]             ds;
    logic [M-1:0][NBITS-1:0]  w_arr;
    logic [SW-1:0]            s;
    logic [SW:0]              t;
    logic [SW:0]              l;
    logic [NBITS-1:0]         vn;

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_lane
            assign w_arr[gi] = weights[gi*NBITS +: NBITS];
            snn_delay_lane #(.DMAX(DMAX), .DW(DW)) u_lane (
                .clk          (clk),
                .reset        (reset),
                .shift_en     (enable & delay_tick),
                .spike_in     (input_spikes[gi]),
                .delay_value  (delay_values[gi*DW +: DW]),
                .delay_en     (delay_en[gi]),
                .delayed_spike(ds[gi])
            );
        end
    endgenerate

    // Weighted sum, leak with floor at zero, then saturate to NBITS.
    always_comb begin
        s = '0;
        for (int i = 0; i < M; i++)
            if (ds[i]) s = s + SW'(w_arr[i]);
        t  = (SW+1)'(v) + (SW+1)'(s);
        l  = (t > (SW+1)'(decay)) ? t - (SW+1)'(decay) : '0;
        vn = (l > (SW+1)'(VMAX)) ? VMAX : l[NBITS-1:0];
    end

    // Neuron FSM. The counter is loaded with P-1 so that a spike at edge k
    // keeps the neuron refractory for edges k+1..k+P; P=0 skips the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= INTEGRATE;
            v           <= '0;
            refr_cnt    <= '0;
            spike_out   <= 1'b0;
            spike_count <= '0;
        end else if (!enable) begin
            spike_out <= 1'b0;
        end else begin
            case (state)
                INTEGRATE: begin
                    if (vn >= threshold) begin
                        spike_out <= 1'b1;
                        v         <= '0;
                        if (spike_count != CMAX)
                            spike_count <= spike_count + 1'b1;
                        if (refractory_period != '0) begin
                            state    <= REFRACTORY;
                            refr_cnt <= refractory_period - 1'b1;
                        end
                    end else begin
                        spike_out <= 1'b0;
                        v         <= vn;
                    end
                end
                REFRACTORY: begin
                    spike_out <= 1'b0;
                    v         <= '0;
                    if (refr_cnt == '0)
                        state <= INTEGRATE;
                    else
                        refr_cnt <= refr_cnt - 1'b1;
                end
                default: state <= INTEGRATE;
            endcase
        end
    end

    assign membrane_potential_out = v;
    assign refractory_out         = (state == REFRACTORY);
endmodule

// File: tb/tb_snn_neuron_delay_param.sv
// Bench for snn_neuron_delay_param: table of single-cycle vectors plus
// hand-written multi-cycle sequences, checked through an expectation queue.
module tb_snn_neuron_delay_param;
    logic       clk = 1'b0;
    logic       reset, enable, delay_tick;
    logic [1:0] input_spikes;
    logic [7:0] weights;
    logic [3:0] threshold, decay, refractory_period;
    logic [5:0] delay_values;
    logic [1:0] delay_en;
    logic [3:0] membrane_potential_out;
    logic       spike_out, refractory_out;
    logic [7:0] spike_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string nm;
        int rst, en, tk, sp, w0, w1, thr, dec, per, d0, d1, den;
        int ev, es, er, ec;   // ec < 0: count not checked
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    snn_neuron_delay_param dut (
        .clk                   (clk),
        .reset                 (reset),
        .enable                (enable),
        .delay_tick            (delay_tick),
        .input_spikes          (input_spikes),
        .weights               (weights),
        .threshold             (threshold),
        .decay                 (decay),
        .refractory_period     (refractory_period),
        .delay_values          (delay_values),
        .delay_en              (delay_en),
        .membrane_potential_out(membrane_potential_out),
        .spike_out             (spike_out),
        .refractory_out        (refractory_out),
        .spike_count           (spike_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, int rst, int en, int tk, int sp,
                                int w0, int w1, int thr, int dec, int per,
                                int d0, int d1, int den,
                                int ev, int es, int er, int ec);
        vec_t r;
        r.nm = nm; r.rst = rst; r.en = en; r.tk = tk; r.sp = sp;
        r.w0 = w0; r.w1 = w1; r.thr = thr; r.dec = dec; r.per = per;
        r.d0 = d0; r.d1 = d1; r.den = den;
        r.ev = ev; r.es = es; r.er = er; r.ec = ec;
        return r;
    endfunction

    task automatic cmp(string nm, string what, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s %s got %0d expected %0d", nm, what, act, req);
        end
    endtask

    // Drive one cycle, queue its expectation, and check it after the edge.
    task automatic step(input vec_t r);
        vec_t e;
        reset             = r.rst[0];
        enable            = r.en[0];
        delay_tick        = r.tk[0];
        input_spikes      = r.sp[1:0];
        weights           = {r.w1[3:0], r.w0[3:0]};
        threshold         = r.thr[3:0];
        decay             = r.dec[3:0];
        refractory_period = r.per[3:0];
        delay_values      = {r.d1[2:0], r.d0[2:0]};
        delay_en          = r.den[1:0];
        exp_q.push_back(r);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        cmp(e.nm, "v", int'(membrane_potential_out), e.ev);
        cmp(e.nm, "spike", int'(spike_out), e.es);
        cmp(e.nm, "refr", int'(refractory_out), e.er);
        if (e.ec >= 0) cmp(e.nm, "count", int'(spike_count), e.ec);
    endtask

    task automatic rst_step(string nm);
        step(mk(nm, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0));
    endtask

    initial begin
        // name             rst en tk sp  w0 w1 thr dec per d0 d1 den  ev es er ec
        tbl.push_back(mk("reset",     1,1,0,0,  0,0, 0,0,0, 0,0,0,  0,0,0,0));
        tbl.push_back(mk("both_fire", 0,1,0,3,  3,3, 5,0,0, 0,0,0,  0,1,0,1));
        tbl.push_back(mk("idle",      0,1,0,0,  3,3, 5,0,0, 0,0,0,  0,0,0,1));
        tbl.push_back(mk("one_in",    0,1,0,1,  3,3, 5,0,0, 0,0,0,  3,0,0,1));
        tbl.push_back(mk("accum",     0,1,0,1,  3,3, 5,0,0, 0,0,0,  0,1,0,2));
        tbl.push_back(mk("sat_fire",  0,1,0,3, 15,15,15,0,0,0,0,0,  0,1,0,3));
        tbl.push_back(mk("thr0_a",    0,1,0,0, 15,15,0,0,0, 0,0,0,  0,1,0,4));
        tbl.push_back(mk("thr0_b",    0,1,0,0, 15,15,0,0,0, 0,0,0,  0,1,0,5));
        tbl.push_back(mk("leak_rst",  1,1,0,0,  0,0, 0,0,0, 0,0,0,  0,0,0,0));
        tbl.push_back(mk("leak0",     0,1,0,1,  4,0,10,1,0, 0,0,0,  3,0,0,0));
        tbl.push_back(mk("leak1",     0,1,0,0,  4,0,10,1,0, 0,0,0,  2,0,0,-1));
        tbl.push_back(mk("leak2",     0,1,0,0,  4,0,10,1,0, 0,0,0,  1,0,0,-1));
        tbl.push_back(mk("leak3",     0,1,0,0,  4,0,10,1,0, 0,0,0,  0,0,0,-1));
        tbl.push_back(mk("leak4",     0,1,0,0,  4,0,10,1,0, 0,0,0,  0,0,0,0));

        reset = 1'b1; enable = 1'b1; delay_tick = 1'b0; input_spikes = '0;
        weights = '0; threshold = '0; decay = '0; refractory_period = '0;
        delay_values = '0; delay_en = '0;
        @(negedge clk);

        foreach (tbl[i]) step(tbl[i]);

        // Refractory P=2: spike at k, inputs ignored at k+1,k+2, fires at k+3.
        rst_step("refr_rst");
        step(mk("refr_k",   0,1,0,3, 3,3,5,0,2, 0,0,0, 0,1,1,1));
        step(mk("refr_k1",  0,1,0,3, 3,3,5,0,2, 0,0,0, 0,0,1,1));
        step(mk("refr_k2",  0,1,0,3, 3,3,5,0,2, 0,0,0, 0,0,0,1));
        step(mk("refr_k3",  0,1,0,3, 3,3,5,0,2, 0,0,0, 0,1,1,2));

        // Refractory P=0: integrating again on the very next edge.
        rst_step("p0_rst");
        step(mk("p0_k",     0,1,0,3, 3,3,5,0,0, 0,0,0, 0,1,0,1));
        step(mk("p0_k1",    0,1,0,3, 3,3,5,0,0, 0,0,0, 0,1,0,2));

        // Delay 3 ticks on synapse 0, then passthrough with d0=0.
        rst_step("dly_rst");
        step(mk("dly_e0",   0,1,1,1, 4,0,15,0,0, 3,0,1, 0,0,0,-1));
        step(mk("dly_e1",   0,1,1,0, 4,0,15,0,0, 3,0,1, 0,0,0,-1));
        step(mk("dly_e2",   0,1,1,0, 4,0,15,0,0, 3,0,1, 0,0,0,-1));
        step(mk("dly_e3",   0,1,1,0, 4,0,15,0,0, 3,0,1, 4,0,0,-1));
        step(mk("dly_e4",   0,1,1,0, 4,0,15,0,0, 3,0,1, 4,0,0,-1));
        step(mk("dly_d0",   0,1,1,1, 4,0,15,0,0, 0,0,1, 8,0,0,0));

        // Maximum delay: contribution lands exactly DMAX ticks later.
        rst_step("dmax_rst");
        step(mk("dmax_e0",  0,1,1,1, 4,0,15,0,0, 7,0,1, 0,0,0,-1));
        for (int k = 1; k < 7; k++)
            step(mk("dmax_wait", 0,1,1,0, 4,0,15,0,0, 7,0,1, 0,0,0,-1));
        step(mk("dmax_e7",  0,1,1,0, 4,0,15,0,0, 7,0,1, 4,0,0,-1));

        // Spike on a non-tick cycle with delay>0 is dropped.
        rst_step("notick_rst");
        step(mk("notick_a", 0,1,0,1, 4,0,15,0,0, 1,0,1, 0,0,0,-1));
        step(mk("notick_b", 0,1,1,0, 4,0,15,0,0, 1,0,1, 0,0,0,-1));
        step(mk("notick_c", 0,1,1,0, 4,0,15,0,0, 1,0,1, 0,0,0,-1));

        // Reset mid-refractory with a spike in flight: pending spike is lost.
        rst_step("mid_rst0");
        step(mk("mid_fire", 0,1,1,3, 3,3,3,0,5, 3,0,1, 0,1,1,1));
        rst_step("mid_rst");
        step(mk("mid_a",    0,1,1,0, 3,3,3,0,5, 3,0,1, 0,0,0,0));
        step(mk("mid_b",    0,1,1,0, 3,3,3,0,5, 3,0,1, 0,0,0,0));
        step(mk("mid_c",    0,1,1,0, 3,3,3,0,5, 3,0,1, 0,0,0,0));

        // enable=0 freezes V, FSM, counter and the delay lines.
        rst_step("en_rst");
        step(mk("en_load",  0,1,0,1, 3,3,10,0,0, 0,0,0, 3,0,0,0));
        step(mk("en_off_a", 0,0,0,3, 3,3,10,0,0, 0,0,0, 3,0,0,0));
        step(mk("en_off_b", 0,0,0,3, 3,3,0,0,0,  0,0,0, 3,0,0,0));
        step(mk("en_on",    0,1,0,0, 3,3,10,0,0, 0,0,0, 3,0,0,0));
        step(mk("en_fire",  0,1,0,0, 3,3,0,0,0,  0,0,0, 0,1,0,1));
        rst_step("en_dly_rst");
        step(mk("en_dly_a", 0,0,1,1, 4,0,15,0,0, 1,0,1, 0,0,0,-1));
        step(mk("en_dly_b", 0,1,1,0, 4,0,15,0,0, 1,0,1, 0,0,0,-1));

        // Spike counter saturates at 255.
        rst_step("cnt_rst");
        for (int k = 0; k < 255; k++)
            step(mk("cnt_run", 0,1,0,0, 0,0,0,0,0, 0,0,0, 0,1,0,-1));
        step(mk("cnt_sat_a", 0,1,0,0, 0,0,0,0,0, 0,0,0, 0,1,0,255));
        step(mk("cnt_sat_b", 0,1,0,0, 0,0,0,0,0, 0,0,0, 0,1,0,255));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
